serial_rx_mc: RTL and testbench
===============================

# serial_rx_mc

Multi-channel, parametrised serial word receiver that captures up to `P_NCH` synchronous serial lines in lock-step, MSB- or LSB-first, with run-time bit count and timing. Successor to the single-channel counter-slaved receiver. It adds:

- a start/valid handshake;
- an internal timebase relative to `start`;
- double-buffered outputs;
- optional majority-vote sampling.

It sits behind the serial-bus front ends (ADC/DAC readback, slow-control shift chains) and feeds register-file captures.

## Interface
- `P_NCH`, 4, number of serial channels sampled in parallel.
- `P_DATA_WIDTH`, 64, max bits per word (1..256).
- `P_CNT_WIDTH`, 32, width of `n0`/`n1` and internal timer.
- `clk` input 1 — clock.
- `rst` input 1 — reset, synchronous, active-high.
- `start` input 1 — begin a capture; accepted only in IDLE.
- `a` input `P_NCH` — serial data, one bit per channel.
- `nbits` input 8 — bits per word; 0 is treated as 1; values above `P_DATA_WIDTH` are clamped to `P_DATA_WIDTH`.
- `n0` input `P_CNT_WIDTH` — lead-in cycles before bit timing starts; 0 is treated as 1.
- `n1` input `P_CNT_WIDTH` — cycles per bit; 0 is treated as 1.
- `lsb_first` input 1 — 0 = MSB first, 1 = LSB first.
- `data` output `P_NCH*P_DATA_WIDTH` — channel c occupies bits `[c*P_DATA_WIDTH +: P_DATA_WIDTH]`, right-aligned, upper unused bits 0.
- `valid` output 1 — one-cycle pulse when `data` updates.
- `busy` output 1 — high from start acceptance until the `valid` cycle.
- `start_err` output 1 — one-cycle pulse when `start` arrives while busy.

## Operation
- States: IDLE, LEAD, SHIFT, DONE.
- **IDLE**
  - On `start`=1, latch the clamped `nbits`, `n0`, `n1` and `lsb_first`.
  - Clear the shift registers and the timer, set the bit index to 0, and go to LEAD.
  - Later changes on these config inputs are ignored until the next capture.
- **LEAD**
  - The timer counts up.
  - When timer == `n0`-1, reset the timer and go to SHIFT.
- **SHIFT**
  - The timer counts up.
  - When timer == `n1`-1, sample every channel, increment the bit index and reset the timer.
  - After sample number `nbits` (index == `nbits`-1), go to DONE.
- **Sample placement**
  - MSB first: `sr <= {sr[W-2:0], bit}`.
  - LSB first: `sr[index] <= bit`.
  - Either way, word bit k sits at `data` bit k after completion.
- **DONE**
  - Copy all shift registers to `data`, pulse `valid`, go to IDLE.
  - `data` holds its value until the next DONE.
- **Back-pressure and errors**
  - `start` while not IDLE: ignored, and `start_err` pulses.
  - `start` in the DONE cycle: also ignored, with `start_err`.
- **Reset** (any time, including mid-capture): state IDLE; `data`=0, `valid`=0, `busy`=0, `start_err`=0; timer, index and shift registers = 0. Any partial word is discarded.
- **Arithmetic**
  - Timer compare is on `P_CNT_WIDTH` bits; no wrap occurs because the timer resets at every compare.
  - The index is 8 bits wide.

## Timing
- Let `start` be sampled at edge t.
- LEAD begins at t+1 and ends after `n0` cycles.
- Sample k (0-based) is taken at edge t + `n0` + (k+1)·`n1`.
- Last sample at t + `n0` + `nbits`·`n1`.
- `valid`=1 and new `data` appear in the cycle after the next edge, i.e. they are registered at t + `n0` + `nbits`·`n1` + 1.
- `busy` rises at t+1 and falls together with the `valid` cycle end.
- Minimum back-to-back period: `n0` + `nbits`·`n1` + 2 cycles.

## Configuration
- Macro: `SERIAL_RX_MAJORITY_EN`.
- **Defined:** each channel keeps a 3-deep register history of `a`. The sampled bit is the majority of `a` at edges s-2, s-1 and s.
  - Recommended `n1` ≥ 3.
  - With `n1` < 3 the vote still uses the 3-deep history.
  - The history is cleared by `rst`.
- **Undefined:** the sampled bit is `a` at edge s directly. No history registers exist.
- Handshake timing is identical in both builds.

## Structure
- Package `serial_rx_pkg` holds:
  - the state enum (IDLE/LEAD/SHIFT/DONE) and its 2-bit width;
  - the `nbits` clamp function;
  - the localparam for max `P_DATA_WIDTH` (256).
- Sub-module `serial_rx_ch`: one per channel, generated `P_NCH` times.
  - Inputs: sample strobe, clear, index, `lsb_first`, `a` bit.
  - Contains the optional majority history and the shift register.
- The top level holds the FSM, timer, index and output buffer.

## Test plan
- **Reset and idle:** after `rst`, `data`=0, `valid`=0, `busy`=0; `start` never asserted → outputs stay 0 for 1000 cycles.
- **MSB first, 4 channels:** `nbits`=8, `n0`=3, `n1`=4.
  - Drive 0xA5, 0x3C, 0xFF, 0x00, each bit held 4 cycles aligned to the sample edges.
  - Required: `valid` at t+36 and `data` channels = 0xA5, 0x3C, 0xFF, 0x00.
- **LSB first:** same waveform as the MSB-first case with `lsb_first`=1 → channel 0 = 0xA5 bit-reversed = 0xA5; channel 1 = 0x3C.
- **Clamps:**
  - `nbits`=0, `n0`=0, `n1`=0 → single bit captured, `valid` at t+3.
  - `nbits`=255 with `P_DATA_WIDTH`=64 → 64 bits captured.
- **Busy handling:** `start` pulsed mid-SHIFT and in the DONE cycle → `start_err` pulses each time; the capture is unaffected. Reset asserted mid-SHIFT → `data` = 0, IDLE; the next capture is correct.
- **Majority build:** with `SERIAL_RX_MAJORITY_EN`, `n1`=5, a single-cycle glitch injected at each sample edge → the captured word equals the glitch-free value. The same stimulus without the macro → the glitched bits are captured.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types for the multi-channel serial word receiver: FSM state encoding,
// the bits-per-word clamp and the hard ceiling on word width.
package serial_rx_pkg;

   localparam int MAX_DATA_WIDTH = 256;
   localparam int ST_W           = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // 0 means one bit; anything wider than the datapath is cut to the datapath width.
   function automatic logic [8:0] clamp_nbits(input logic [7:0] n, input int w);
      logic [8:0] r;
      r = {1'b0, n};
      if (r == 9'd0) r = 9'd1;
      if ({23'd0, r} > w[31:0]) r = w[8:0];
      return r;
   endfunction

endpackage

// File: rtl/serial_rx_ch.sv
// One serial lane: optional 3-tap majority history (SERIAL_RX_MAJORITY_EN) feeding
// a shift register that takes one bit per sample strobe; no backpressure.
module serial_rx_ch
   import serial_rx_pkg::*;
#(
   parameter int P_DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    smp,
   input  logic [7:0]              idx,
   input  logic                    lsb_first,
   input  logic                    a,
   output logic [P_DATA_WIDTH-1:0] sr
);

   logic                    bit_s;
   logic [P_DATA_WIDTH-1:0] bit_v;

`ifdef SERIAL_RX_MAJORITY_EN
   // hist[0] holds the line at the previous edge, hist[1] the one before that.
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) hist <= '0;
      else     hist <= {hist[0], a};
   end

   assign bit_s = (a & hist[0]) | (a & hist[1]) | (hist[0] & hist[1]);
`else
   assign bit_s = a;
`endif

   always_comb begin
      bit_v    = '0;
      bit_v[0] = bit_s;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sr <= '0;
      end else if (smp) begin
         if (lsb_first) sr <= sr | (bit_v << idx);
         else           sr <= (sr << 1) | bit_v;
      end
   end

endmodule

// File: rtl/serial_rx_mc.sv
// Lock-step serial word receiver for P_NCH lanes; valid lands n0 + nbits*n1 + 1 cycles
// after start. start while busy is dropped with a start_err pulse. Optional: SERIAL_RX_MAJORITY_EN.
module serial_rx_mc
   import serial_rx_pkg::*;
#(
   parameter int P_NCH        = 4,
   parameter int P_DATA_WIDTH = 64,
   parameter int P_CNT_WIDTH  = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [P_NCH-1:0]                a,
   input  logic [7:0]                      nbits,
   input  logic [P_CNT_WIDTH-1:0]          n0,
   input  logic [P_CNT_WIDTH-1:0]          n1,
   input  logic                            lsb_first,
   output logic [P_NCH*P_DATA_WIDTH-1:0]   data,
   output logic                            valid,
   output logic                            busy,
   output logic                            start_err
);

   localparam int W_EFF = (P_DATA_WIDTH > MAX_DATA_WIDTH) ? MAX_DATA_WIDTH : P_DATA_WIDTH;
   localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                          state, nxt;
   logic [P_CNT_WIDTH-1:0]          timer;
   logic [P_CNT_WIDTH-1:0]          n0_q, n1_q;
   logic [7:0]                      idx;
   logic [8:0]                      nb_q;
   logic                            lsb_q;
   logic                            clr, smp, tmr_hit;
   logic [P_NCH*P_DATA_WIDTH-1:0]   sr_all;

   always_comb begin
      nxt     = state;
      clr     = 1'b0;
      smp     = 1'b0;
      tmr_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               nxt = ST_LEAD;
               clr = 1'b1;
            end
         end
         ST_LEAD: begin
            tmr_hit = (timer == n0_q - CNT_ONE);
            if (tmr_hit) nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            tmr_hit = (timer == n1_q - CNT_ONE);
            smp     = tmr_hit;
            if (tmr_hit && ({1'b0, idx} == nb_q - 9'd1)) nxt = ST_DONE;
         end
         ST_DONE: nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         idx       <= '0;
         nb_q      <= 9'd1;
         n0_q      <= CNT_ONE;
         n1_q      <= CNT_ONE;
         lsb_q     <= 1'b0;
         data      <= '0;
         valid     <= 1'b0;
         start_err <= 1'b0;
      end else begin
         state     <= nxt;
         valid     <= (state == ST_DONE);
         start_err <= start && (state != ST_IDLE);
         if (state == ST_DONE) data <= sr_all;

         // Config is frozen at acceptance so the front end may retarget it mid-word.
         if (clr) begin
            nb_q  <= clamp_nbits(nbits, W_EFF);
            n0_q  <= (n0 == '0) ? CNT_ONE : n0;
            n1_q  <= (n1 == '0) ? CNT_ONE : n1;
            lsb_q <= lsb_first;
            timer <= '0;
            idx   <= '0;
         end else if (state == ST_LEAD || state == ST_SHIFT) begin
            timer <= tmr_hit ? '0 : timer + CNT_ONE;
         end

         if (smp) idx <= idx + 8'd1;
      end
   end

   // The output word stays owned by the caller during the valid cycle, hence busy.
   assign busy = (state != ST_IDLE) || valid;

   for (genvar c = 0; c < P_NCH; c++) begin : g_ch
      serial_rx_ch #(
         .P_DATA_WIDTH (P_DATA_WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .smp       (smp),
         .idx       (idx),
         .lsb_first (lsb_q),
         .a         (a[c]),
         .sr        (sr_all[c*P_DATA_WIDTH +: P_DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_serial_rx_mc.sv
// Bench for serial_rx_mc: a timeline model of captured words checked every cycle,
// plus literal expectations for the directed cases.
module tb_serial_rx_mc;

   localparam int NCH = 4;
   localparam int W   = 64;
   localparam int CW  = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [NCH-1:0]     a = '0;
   logic [7:0]         nbits = 8'd8;
   logic [CW-1:0]      n0 = 32'd3;
   logic [CW-1:0]      n1 = 32'd4;
   logic               lsb_first = 1'b0;
   logic [NCH*W-1:0]   data;
   logic               valid, busy, start_err;

   serial_rx_mc #(
      .P_NCH        (NCH),
      .P_DATA_WIDTH (W),
      .P_CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .nbits     (nbits),
      .n0        (n0),
      .n1        (n1),
      .lsb_first (lsb_first),
      .data      (data),
      .valid     (valid),
      .busy      (busy),
      .start_err (start_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;

   // ---------------- timeline model ----------------
   int             cyc = 0;
   logic [NCH-1:0] ah [0:65535];
   bit             m_active = 1'b0;
   bit             m_lsb = 1'b0;
   bit             in_cap;
   int             m_t = 0, m_T = 0, m_nb = 1, m_n0 = 1, m_n1 = 1;
   logic           exp_valid = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
   logic [NCH*W-1:0] exp_data = '0;

   function automatic int ix(input int e);
      return e & 65535;
   endfunction

   // Sample k of the word is the line at edge t + n0 + (k+1)*n1 (or the vote around it).
   function automatic logic [NCH*W-1:0] model_word();
      logic [NCH*W-1:0] d;
      int s, pos, ones;
      logic b;
      d = '0;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < m_nb; k++) begin
            s = m_t + m_n0 + (k + 1) * m_n1;
`ifdef SERIAL_RX_MAJORITY_EN
            ones = int'(ah[ix(s-2)][c]) + int'(ah[ix(s-1)][c]) + int'(ah[ix(s)][c]);
            b = (ones >= 2);
`else
            ones = 0;
            b = ah[ix(s)][c];
`endif
            pos = m_lsb ? k : (m_nb - 1 - k);
            d[c*W + pos] = b;
         end
      end
      return d;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      ah[ix(cyc)] = rst ? '0 : a;
      if (rst) begin
         m_active = 1'b0;
         exp_valid = 1'b0;
         exp_busy  = 1'b0;
         exp_err   = 1'b0;
         exp_data  = '0;
      end else begin
         in_cap    = m_active && (cyc <= m_T);
         exp_err   = start && in_cap;
         exp_valid = m_active && (cyc == m_T);
         if (exp_valid) exp_data = model_word();
         if (start && !in_cap) begin
            m_nb  = (nbits == 8'd0) ? 1 : int'(nbits);
            if (m_nb > W) m_nb = W;
            m_n0  = (n0 == 0) ? 1 : int'(n0);
            m_n1  = (n1 == 0) ? 1 : int'(n1);
            m_lsb = lsb_first;
            m_t   = cyc;
            m_T   = cyc + m_n0 + m_nb * m_n1 + 1;
            m_active = 1'b1;
         end
         exp_busy = m_active && (cyc <= m_T);
      end
   end

   // ---------------- stimulus helpers ----------------
   int             drv_mode = 0;       // 0 random, 1 bit-aligned words, 2 constant
   logic [7:0]     dw [NCH];
   int             dn0 = 3, dn1 = 4, dnb = 8;
   bit             glitch = 1'b0;
   logic [NCH-1:0] const_a = '0;

   task automatic fail_line(input string name, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] req);
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
   endtask

   task automatic chk_data(input string name, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] req);
      checks++;
      if (got !== req) fail_line(name, got, req);
   endtask

   task automatic chk_int(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, req);
      end
   endtask

   // Advance to the next falling edge, compare all outputs with the model, drive a.
   task automatic step();
      int rel, k;
      logic b;
      @(negedge clk);
      chk_data("valid", {{(NCH*W-1){1'b0}}, valid}, {{(NCH*W-1){1'b0}}, exp_valid});
      chk_data("busy", {{(NCH*W-1){1'b0}}, busy}, {{(NCH*W-1){1'b0}}, exp_busy});
      chk_data("start_err", {{(NCH*W-1){1'b0}}, start_err}, {{(NCH*W-1){1'b0}}, exp_err});
      chk_data("data", data, exp_data);
      if (start_err) err_cnt++;
      case (drv_mode)
         0: a = NCH'($urandom);
         1: begin
            rel = cyc + 1 - m_t - dn0 - 1;
            for (int c = 0; c < NCH; c++) begin
               b = 1'b0;
               if (rel >= 0 && rel / dn1 < dnb) begin
                  k = rel / dn1;
                  b = dw[c][dnb-1-k];
                  if (glitch && (rel % dn1 == dn1 - 1)) b = ~b;
               end
               a[c] = b;
            end
         end
         default: a = const_a;
      endcase
   endtask

   task automatic wait_valid(output int ve);
      ve = -1;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (valid) begin
            ve = cyc;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL valid_timeout cyc=%0d got=no_valid required=valid", cyc);
   endtask

   task automatic run_cfg(input int nb, input int i0, input int i1, input bit lsb,
                          output int t, output int ve);
      nbits = 8'(nb); n0 = CW'(i0); n1 = CW'(i1); lsb_first = lsb;
      start = 1'b1;
      step();
      start = 1'b0;
      t = cyc;
      wait_valid(ve);
   endtask

   task automatic set_words(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input int i0, input int i1, input bit gl);
      dw[0] = w0; dw[1] = w1; dw[2] = w2; dw[3] = w3;
      dnb = 8; dn0 = i0; dn1 = i1; glitch = gl; drv_mode = 1;
   endtask

   function automatic logic [NCH*W-1:0] pack4(input logic [7:0] w0, input logic [7:0] w1,
                                              input logic [7:0] w2, input logic [7:0] w3);
      logic [NCH*W-1:0] d;
      d = '0;
      d[0*W +: 8] = w0;
      d[1*W +: 8] = w1;
      d[2*W +: 8] = w2;
      d[3*W +: 8] = w3;
      return d;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int t, ve, e0;
      logic [NCH*W-1:0] req;

      repeat (3) step();
      rst = 1'b0;
      drv_mode = 0;
      repeat (1000) step();
      chk_data("idle_data", data, '0);
      chk_int("idle_busy", int'(busy), 0);

      // MSB first, spec words
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 3, 4, 1'b0);
      run_cfg(8, 3, 4, 1'b0, t, ve);
      chk_int("msb_valid_time", ve, t + 36);
      chk_data("msb_data", data, pack4(8'hA5, 8'h3C, 8'hFF, 8'h00));
      repeat (3) step();

      // LSB first, same waveform; non-palindromic lanes expose bit order
      set_words(8'hA5, 8'h3C, 8'h01, 8'hC8, 3, 4, 1'b0);
      run_cfg(8, 3, 4, 1'b1, t, ve);
      chk_int("lsb_valid_time", ve, t + 36);
      chk_data("lsb_data", data, pack4(8'hA5, 8'h3C, 8'h80, 8'h13));
      repeat (2) step();

      // zero clamps: one bit, valid three edges after start
      drv_mode = 2; const_a = 4'b1011;
      run_cfg(0, 0, 0, 1'b0, t, ve);
      chk_int("clamp0_valid_time", ve, t + 3);
      req = '0; req[0] = 1'b1; req[W] = 1'b1; req[3*W] = 1'b1;
      chk_data("clamp0_data", data, req);
      repeat (2) step();

      // nbits above width: 64 bits captured
      const_a = 4'b0110;
      run_cfg(255, 2, 1, 1'b0, t, ve);
      chk_int("clamp255_valid_time", ve, t + 2 + 64 + 1);
      req = '0; req[W +: W] = '1; req[2*W +: W] = '1;
      chk_data("clamp255_data", data, req);
      repeat (2) step();

      // start mid-SHIFT and in the DONE cycle
      set_words(8'h5A, 8'h81, 8'h7E, 8'h0F, 3, 4, 1'b0);
      nbits = 8'd8; n0 = 32'd3; n1 = 32'd4; lsb_first = 1'b0;
      e0 = err_cnt;
      start = 1'b1; step(); start = 1'b0; t = cyc;
      while (cyc < t + 10) step();
      start = 1'b1; step(); start = 1'b0;
      while (cyc < t + 35) step();
      start = 1'b1; step(); start = 1'b0;
      chk_int("busy_valid_at_done", int'(valid), 1);
      chk_data("busy_data", data, pack4(8'h5A, 8'h81, 8'h7E, 8'h0F));
      repeat (3) step();
      chk_int("busy_err_pulses", err_cnt - e0, 2);
      chk_int("busy_idle_after", int'(busy), 0);

      // reset mid-SHIFT discards the word and the output buffer
      set_words(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 4, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      repeat (15) step();
      rst = 1'b1; repeat (2) step(); rst = 1'b0;
      step();
      chk_data("rst_mid_data", data, '0);
      chk_int("rst_mid_busy", int'(busy), 0);
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 3, 4, 1'b0);
      run_cfg(8, 3, 4, 1'b0, t, ve);
      chk_int("after_rst_valid_time", ve, t + 36);
      chk_data("after_rst_data", data, pack4(8'hA5, 8'h3C, 8'hFF, 8'h00));
      repeat (2) step();

      // single-cycle glitch on every sample edge
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h00, 3, 5, 1'b1);
      run_cfg(8, 3, 5, 1'b0, t, ve);
      chk_int("glitch_valid_time", ve, t + 44);
`ifdef SERIAL_RX_MAJORITY_EN
      chk_data("glitch_data", data, pack4(8'hA5, 8'h3C, 8'hFF, 8'h00));
`else
      chk_data("glitch_data", data, pack4(8'h5A, 8'hC3, 8'h00, 8'hFF));
`endif
      glitch = 1'b0;
      repeat (2) step();

      // random traffic: config churn, start storms, occasional reset
      drv_mode = 0;
      for (int i = 0; i < 4000; i++) begin
         start     = ($urandom_range(5) == 0);
         nbits     = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(11));
         n0        = CW'($urandom_range(4));
         n1        = CW'($urandom_range(3));
         lsb_first = 1'($urandom_range(1));
         rst       = ($urandom_range(699) == 0);
         step();
      end
      rst = 1'b0; start = 1'b0;
      repeat (300) step();
      chk_int("final_idle_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
